// File: rtl/axi4_pkg.sv
// Shared types and helpers for the AXI4 write responder.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_slave_mem.sv
// Word memory with one write port and a registered read port.
// A read of the word being written in the same cycle returns the old word.
module axi4_slave_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int IDX_WIDTH    = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_write_responder.sv
// AXI4 write-channel slave: accepts one INCR burst at a time into local memory
// and returns a B response. Moore outputs are registered from the next state.
//
//   state | meaning
//   IDLE  | AWREADY high, waiting for an address
//   DATA  | WREADY high, accepting AWLEN+1 beats
//   RESP  | BVALID high, holding BRESP until BREADY
module axi4_write_responder
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [ADDR_WIDTH-1:0]           AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [2:0]                      AWSIZE,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [DATA_WIDTH-1:0]           WDATA,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [$clog2(MEMORY_DEPTH)-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0]           DBG_DATA
);

  localparam int          LSB       = addr_lsb(DATA_WIDTH);
  localparam int          IDX_WIDTH = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] DEPTH_U   = 32'(MEMORY_DEPTH);

  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [7:0]            beats_left_q;
  logic                  err_q, err_d;
  logic                  size_err_q;
  logic                  aw_fire, w_fire, b_fire;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range, last_beat, mem_we;

  assign aw_fire   = AWVALID && AWREADY;
  assign w_fire    = WVALID && WREADY;
  assign b_fire    = BVALID && BREADY;
  assign word_idx  = addr_q >> LSB;
  assign in_range  = 32'(word_idx) < DEPTH_U;
  // Down-counter of beats still owed after the current one; zero marks the final beat.
  assign last_beat = (beats_left_q == 8'd0);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_fire) begin
          state_d = DATA;
          err_d   = (AWSIZE != 3'(LSB));
        end
      end
      DATA: begin
        if (w_fire) begin
          mem_we = in_range && !size_err_q;
          if (!in_range) err_d = 1'b1;
          if (WLAST != last_beat) err_d = 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        if (b_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      AWREADY      <= 1'b0;
      WREADY       <= 1'b0;
      BVALID       <= 1'b0;
      BRESP        <= RESP_OKAY;
      err_q        <= 1'b0;
      size_err_q   <= 1'b0;
      beats_left_q <= 8'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      AWREADY <= (state_d == IDLE);
      WREADY  <= (state_d == DATA);
      BVALID  <= (state_d == RESP);
      BRESP   <= ((state_d == RESP) && err_d) ? RESP_SLVERR : RESP_OKAY;
      if (aw_fire) begin
        beats_left_q <= AWLEN;
        size_err_q   <= (AWSIZE != 3'(LSB));
      end else if (w_fire && !last_beat) begin
        beats_left_q <= beats_left_q - 8'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_fire) begin
      addr_q <= AWADDR;
      size_q <= AWSIZE;
    end else if (w_fire) begin
      addr_q <= addr_q + (ADDR_WIDTH'(1) << size_q);
    end
  end

  axi4_slave_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_mem (
    .clk  (ACLK),
    .we   (mem_we),
    .waddr(IDX_WIDTH'(word_idx)),
    .wdata(WDATA),
    .raddr(DBG_ADDR),
    .rdata(DBG_DATA)
  );

endmodule

// File: tb/tb_axi4_write_responder.sv
// Directed bench for axi4_write_responder with a burst-level reference model.
module tb_axi4_write_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [9:0]  DBG_ADDR;
  logic [31:0] DBG_DATA;

  axi4_write_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected memory image, pending B responses, accepted beat total.
  logic [31:0] exp_mem   [1024];
  bit          exp_known [1024];
  logic [1:0]  exp_b [$];
  int          exp_beats  = 0;
  int          seen_beats = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare process: B channel against the model, hold stability, single-outstanding rule.
  logic       prev_bvalid = 1'b0;
  logic       prev_bready = 1'b0;
  logic [1:0] prev_bresp  = 2'b00;
  always @(negedge ACLK) begin
    #1;
    if (ARESET) begin
      prev_bvalid = 1'b0;
      prev_bready = 1'b0;
    end else begin
      if (prev_bvalid && !prev_bready)
        chk("b_hold", {BVALID, BRESP}, {1'b1, prev_bresp});
      if (BVALID) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_b actual=BVALID expected=no_response_pending");
        end else begin
          chk("bresp_model", BRESP, exp_b[0]);
          if (BREADY) void'(exp_b.pop_front());
        end
      end
      if (AWREADY) chk("single_outstanding", {WREADY, BVALID}, 2'b00);
      if (WVALID && WREADY) seen_beats++;
      prev_bvalid = BVALID;
      prev_bready = BREADY;
      prev_bresp  = BRESP;
    end
  end

  task automatic wait_ready(input string name, input bit which_w);
    int n = 0;
    while (((which_w ? WREADY : AWREADY) !== 1'b1) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=not_ready expected=ready_within_50", name);
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic do_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [31:0] d0, input logic [31:0] dstep,
                          input logic [15:0] wlast_mask, input int bdelay, input bit probe,
                          output logic [1:0] got_resp);
    logic [15:0] a;
    int          idx;
    bit          err, serr;
    logic [9:0]  probe_idx;
    logic [31:0] probe_exp;
    probe_idx = 10'(addr >> 2);
    probe_exp = exp_mem[probe_idx];
    a    = addr;
    serr = (size != 3'd2);
    err  = serr;
    for (int i = 0; i <= int'(len); i++) begin
      idx = int'(a >> 2);
      if (idx >= 1024) err = 1;
      else if (!serr) begin
        exp_mem[idx]   = d0 + dstep * i;
        exp_known[idx] = 1;
      end
      if (wlast_mask[i] != (i == int'(len))) err = 1;
      a = a + (16'd1 << size);
    end
    exp_b.push_back(err ? 2'b10 : 2'b00);
    exp_beats += int'(len) + 1;

    AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
    wait_ready("aw", 1'b0);
    AWVALID = 1'b0;
    chk("aw_to_wready", WREADY, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1;
      WDATA  = d0 + dstep * i;
      WLAST  = wlast_mask[i];
      if (probe && i == 0) DBG_ADDR = probe_idx;
      wait_ready("w", 1'b1);
      if (probe && i == 0) chk("read_before_write", DBG_DATA, probe_exp);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    chk("wready_drop", WREADY, 1'b0);
    chk("last_to_bvalid", BVALID, 1'b1);
    got_resp = BRESP;
    repeat (bdelay) begin
      chk("bvalid_wait", BVALID, 1'b1);
      chk("awready_wait", AWREADY, 1'b0);
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("awready_after_b", AWREADY, 1'b1);
    chk("bvalid_after_b", BVALID, 1'b0);
  endtask

  task automatic dbg_read(input int idx, output logic [31:0] data);
    DBG_ADDR = 10'(idx);
    @(posedge ACLK);
    @(negedge ACLK);
    data = DBG_DATA;
    if (exp_known[idx]) chk("dbg_model", data, exp_mem[idx]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) begin
      exp_mem[i]   = '0;
      exp_known[i] = 0;
    end
    ARESET = 1'b1; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; DBG_ADDR = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("first_awready", AWREADY, 1'b1);

    // 1: four-beat OKAY burst into words 4..7
    WVALID = 1'b1;
    @(negedge ACLK);
    chk("no_w_before_aw", WREADY, 1'b0);
    WVALID = 1'b0;
    do_burst(16'h0010, 8'd3, 3'd2, 32'hA0, 32'h1, 16'b1000, 0, 0, r);
    chk("t1_resp", r, 2'b00);
    for (int i = 0; i < 4; i++) begin
      dbg_read(4 + i, d);
      chk("t1_dbg", d, 32'hA0 + 32'(i));
    end

    // 2: second beat runs past the end of memory
    do_burst(16'h0FFC, 8'd1, 3'd2, 32'h11, 32'h11, 16'b10, 0, 0, r);
    chk("t2_resp", r, 2'b10);
    dbg_read(1023, d);
    chk("t2_dbg1023", d, 32'h11);

    // 3: early WLAST, then missing WLAST
    do_burst(16'h0040, 8'd2, 3'd2, 32'h30, 32'h1, 16'b010, 0, 0, r);
    chk("t3a_resp", r, 2'b10);
    for (int i = 0; i < 3; i++) begin
      dbg_read(16 + i, d);
      chk("t3a_dbg", d, 32'h30 + 32'(i));
    end
    do_burst(16'h0050, 8'd0, 3'd2, 32'h40, 32'h1, 16'b0, 0, 0, r);
    chk("t3b_resp", r, 2'b10);

    // 4: narrow AWSIZE must leave memory untouched
    do_burst(16'h0100, 8'd1, 3'd2, 32'h55, 32'h11, 16'b10, 0, 0, r);
    do_burst(16'h0100, 8'd1, 3'd1, 32'hDEAD, 32'h1, 16'b10, 0, 0, r);
    chk("t4_resp", r, 2'b10);
    dbg_read(64, d);
    chk("t4_dbg64", d, 32'h55);
    dbg_read(65, d);
    chk("t4_dbg65", d, 32'h66);

    // 5: BREADY held low for 5 cycles
    do_burst(16'h0080, 8'd0, 3'd2, 32'h77, 32'h1, 16'b1, 5, 0, r);
    chk("t5_resp", r, 2'b00);

    // 6: reset after two beats of a four-beat burst
    AWADDR = 16'h0200; AWLEN = 8'd3; AWSIZE = 3'd2; AWVALID = 1'b1;
    wait_ready("t6_aw", 1'b0);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WVALID = 1'b1;
      WDATA  = 32'hC0 + 32'(i);
      WLAST  = 1'b0;
      wait_ready("t6_w", 1'b1);
    end
    exp_mem[128] = 32'hC0; exp_known[128] = 1;
    exp_mem[129] = 32'hC1; exp_known[129] = 1;
    exp_beats += 2;
    WVALID = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("t6_wready", WREADY, 1'b0);
    chk("t6_bvalid", BVALID, 1'b0);
    chk("t6_awready_low", AWREADY, 1'b0);
    @(posedge ACLK);
    @(negedge ACLK);
    chk("t6_awready", AWREADY, 1'b1);
    dbg_read(128, d);
    chk("t6_dbg128", d, 32'hC0);
    do_burst(16'h0010, 8'd0, 3'd2, 32'hB0, 32'h1, 16'b1, 0, 1, r);
    chk("t6_resp", r, 2'b00);
    dbg_read(4, d);
    chk("t6_dbg4", d, 32'hB0);

    repeat (3) @(negedge ACLK);
    chk("beats_accepted", seen_beats, exp_beats);
    chk("b_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_write_responder.md
Name: axi4_write_responder

Overview:
- AXI4 write-channel responder (slave end) with an internal word memory.
- Accepts AW and W bursts from an initiator and stores the beats in memory.
- Returns a B response per burst.
- Provides a registered debug read port so benches can inspect memory contents.
- Sits behind the initiator-side write channels, and is the target the write-channel protocol checks run against.

Parameters:
- DATA_WIDTH, 32, W data width in bits (power of 2, >= 8)
- ADDR_WIDTH, 16, AW byte-address width
- MEMORY_DEPTH, 1024, number of DATA_WIDTH-bit words in memory

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  synchronous, active-high reset
- AWADDR  in  ADDR_WIDTH  burst start byte address
- AWLEN  in  8  beats minus 1
- AWSIZE  in  3  log2 bytes per beat
- AWVALID  in  1  AW valid
- AWREADY  out  1  AW ready
- WDATA  in  DATA_WIDTH  write data
- WLAST  in  1  last beat marker
- WVALID  in  1  W valid
- WREADY  out  1  W ready
- BRESP  out  2  write response (00 OKAY, 10 SLVERR)
- BVALID  out  1  B valid
- BREADY  in  1  B ready
- DBG_ADDR  in  $clog2(MEMORY_DEPTH)  debug word index
- DBG_DATA  out  DATA_WIDTH  memory word at DBG_ADDR, registered

Behaviour:
- Reset: while ARESET=1, on each edge:
  - state <= IDLE
  - AWREADY, WREADY, BVALID <= 0
  - BRESP <= 00
  - error flag and beat counter <= 0
  - Memory contents are not reset; DBG_DATA is not reset.
- FSM states: IDLE, DATA, RESP. Outputs are registered (Moore):
  - IDLE: AWREADY=1
  - DATA: WREADY=1
  - RESP: BVALID=1
  - All other cases: 0
- First AWREADY=1 appears one cycle after ARESET deasserts.
- IDLE:
  - On AWVALID&&AWREADY, latch AWADDR, AWLEN and AWSIZE, clear the beat counter and error flag, and go to DATA.
  - WREADY=1 from the next cycle.
  - If AWSIZE != log2(DATA_WIDTH/8), set the error flag; no beat of that burst writes memory, but all AWLEN+1 beats are still accepted.
- DATA:
  - Each W handshake uses word index = addr >> log2(DATA_WIDTH/8).
  - Index < MEMORY_DEPTH and no size error: write WDATA to that index.
  - Index >= MEMORY_DEPTH: no write; set the error flag.
  - After each beat, addr += 1 << AWSIZE (INCR only), modulo 2^ADDR_WIDTH. The beat counter increments.
  - Burst terminates on the handshake where counter == AWLEN. Next state is RESP and WREADY drops the next cycle.
  - WLAST=1 on an earlier beat: that beat is written normally, the error flag is set, and the burst continues to AWLEN+1 beats.
  - WLAST=0 on the final beat: error flag set.
- RESP:
  - BVALID=1; BRESP = error ? 10 : 00.
  - BRESP and BVALID are held stable until BREADY.
  - On BVALID&&BREADY, go to IDLE; AWREADY=1 on the next cycle.
  - Minimum burst-to-burst gap is one IDLE cycle.
- No W beats are accepted before AW: WREADY=0 in IDLE even if WVALID=1.
- Latency:
  - AW handshake to WREADY: 1 cycle.
  - Last W handshake to BVALID: 1 cycle.
  - DBG_ADDR to DBG_DATA: 1 cycle.
- Debug port and simultaneous write: a debug read of the index being written in the same cycle returns the old word (read-before-write).
- Reset mid-burst: the burst is abandoned and no B response is issued. Beats already written stay in memory.
- Single outstanding write only. AWREADY is never asserted while DATA or RESP is active.

Decomposition:
- Package axi4_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - Enum wr_state_t {IDLE, DATA, RESP}
  - Function addr_lsb(DATA_WIDTH) = log2(DATA_WIDTH/8)
- Sub-module axi4_slave_mem:
  - Single write port plus registered read port, MEMORY_DEPTH x DATA_WIDTH.
  - Read-before-write on address collision.
  - Instantiated once.

Test Plan:
1. Reset, then AWADDR=0x0010, AWLEN=3, AWSIZE=2, WDATA 0xA0..0xA3 with WLAST on beat 3, BREADY=1 -> BRESP=00, BVALID one cycle after the last beat; DBG_ADDR 4..7 reads 0xA0..0xA3.
2. AWADDR=0x0FFC (word 1023), AWLEN=1, AWSIZE=2, data 0x11, 0x22 -> word 1023=0x11; the second beat (word 1024) is dropped; BRESP=10; all 2 beats accepted.
3. AWLEN=2 with WLAST asserted on beat 1 -> all 3 beats written, BRESP=10. Separately, AWLEN=0 with WLAST=0 -> BRESP=10.
4. AWSIZE=1 (DATA_WIDTH=32), AWLEN=1 -> 2 beats accepted, memory unchanged, BRESP=10.
5. BREADY held low 5 cycles -> BVALID and BRESP stable for 5 cycles; AWREADY=0 throughout; AWREADY=1 the cycle after the handshake.
6. ARESET pulsed after beat 1 of a 4-beat burst -> WREADY=0 and BVALID=0 the next cycle; word of beat 0 retained; a following burst completes with OKAY.
